// File: rtl/lsu_mem_port.sv
// lsu_mem_port: blocking load/store unit for the tiny-riscv core.
// Accepts one load or store from execute, drives a req/gnt + rvalid memory
// handshake, and returns formatted load data tagged with its destination.
// Only one transaction is ever in flight; lsu_ready is low until it retires.
module lsu_mem_port #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    // issue from execute
    input  logic              lsu_en,
    output logic              lsu_ready,
    input  logic              ls_is_store,
    input  logic [2:0]        ls_funct3,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [XLEN-1:0]   ls_wdata,
    input  logic [3:0]        ls_rd,
    // data memory
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    // load return to core control
    output logic              ls_load_ready,
    output logic [3:0]        ld_rd,
    output logic [XLEN-1:0]   ld_data,
    output logic              ls_fault
);

    localparam int NUM_LANES = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  f3_q;      // funct3 of the in-flight load, selects formatting
    logic [1:0]  lo_q;      // byte offset of the in-flight load
    logic [3:0]  rd_q;      // destination of the in-flight load

    logic        size_ok;
    logic        align_ok;
    logic        legal;

    logic [NUM_LANES-1:0]      be_nxt;
    logic [NUM_LANES-1:0][7:0] wdata_nxt;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_fmt;

    assign lsu_ready = (state == IDLE);

    // Decide at issue time whether the op exists and is naturally aligned.
    always_comb begin
        size_ok = 1'b0;
        case (ls_funct3)
            3'd0, 3'd1, 3'd2: size_ok = 1'b1;
            3'd4, 3'd5:       size_ok = !ls_is_store;  // LBU/LHU have no store form
            default:          size_ok = 1'b0;
        endcase
        align_ok = 1'b1;
        case (ls_funct3[1:0])
            2'd1:    align_ok = !ls_addr[0];
            2'd2:    align_ok = (ls_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    assign legal = size_ok & align_ok;

    // Per-lane byte enable and store byte. Stores replicate the narrow datum
    // across every lane so the memory only has to honour the byte enables.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam logic [1:0] LID = 2'(g);

        assign be_nxt[g] = !ls_is_store            ? 1'b1 :
                           (ls_funct3[1:0] == 2'd0) ? (ls_addr[1:0] == LID) :
                           (ls_funct3[1:0] == 2'd1) ? (ls_addr[1] == LID[1]) :
                                                      1'b1;

        assign wdata_nxt[g] = !ls_is_store            ? ls_wdata[8*g +: 8] :
                              (ls_funct3[1:0] == 2'd0) ? ls_wdata[7:0] :
                              (ls_funct3[1:0] == 2'd1) ? ls_wdata[8*(g%2) +: 8] :
                                                         ls_wdata[8*g +: 8];
    end

    // Pick the addressed byte/halfword of the returned word and extend it.
    always_comb begin
        ld_byte = mem_rdata[{lo_q, 3'b000} +: 8];
        ld_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'd0:    ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'd1:    ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'd4:    ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
            3'd5:    ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_fmt = mem_rdata;
        endcase
    end

    // Transaction FSM with all memory and writeback outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
            ls_load_ready <= 1'b0;
            ls_fault      <= 1'b0;
            ld_rd         <= '0;
            ld_data       <= '0;
            f3_q          <= '0;
            lo_q          <= '0;
            rd_q          <= '0;
        end else begin
            ls_load_ready <= 1'b0;
            ls_fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu_en) begin
                        if (legal) begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= ls_is_store;
                            mem_addr  <= {ls_addr[ADDR_W-1:2], 2'b00};
                            mem_be    <= be_nxt;
                            mem_wdata <= wdata_nxt;
                            f3_q      <= ls_funct3;
                            lo_q      <= ls_addr[1:0];
                            rd_q      <= ls_rd;
                        end else begin
                            // Faulting ops never touch the bus.
                            ls_fault <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // Request fields hold until the grant; rvalid is ignored here.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= mem_we ? IDLE : WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        ld_data       <= ld_fmt;
                        ld_rd         <= rd_q;
                        // x0 loads retire silently so no bypass can match x0.
                        ls_load_ready <= (rd_q != 4'd0);
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: a driver issues ops and pushes the
// expected bus request / fault from a byte-level model; a memory responder
// checks requests and queues the expected load result; a monitor checks
// every writeback and fault pulse against the queues.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_en, lsu_ready, ls_is_store;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_rd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        ls_load_ready, ls_fault;
    logic [3:0]  ld_rd;
    logic [31:0] ld_data;

    lsu_mem_port #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .lsu_en(lsu_en), .lsu_ready(lsu_ready), .ls_is_store(ls_is_store),
        .ls_funct3(ls_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rd(ls_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ls_load_ready(ls_load_ready), .ld_rd(ld_rd), .ld_data(ld_data), .ls_fault(ls_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] baddr;
        logic [3:0]  rd;
        bit          drop;
    } bus_t;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
    } ld_t;

    bus_t bus_q[$];
    ld_t  ld_q[$];
    bit   fault_at[int];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_issue = 0;
    int last_ld_cyc = -100;
    int r_last_gnt = -100;

    // responder knobs and state
    bit          fix_mode;
    int          fix_gnt, fix_rv;
    logic [31:0] fix_rdata;
    bit          r_wait_ph = 1'b0;
    bit          r_seen = 1'b0;
    bus_t        r_cur;
    int          r_stall = 0;
    int          r_wait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Access size in bytes, 0 for an op that does not exist.
    function automatic int op_bytes(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int nb;
        logic [63:0] mask, v;
        nb   = op_bytes(1'b0, f3);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = ({32'd0, rdata} >> (8 * (addr % 4))) & mask;
        if (f3 < 3'd4 && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_be(input logic st, input int nb, input logic [31:0] addr);
        logic [31:0] m;
        if (!st) return 4'hF;
        m = ((32'd1 << nb) - 32'd1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wd(input int nb, input logic [31:0] wd);
        if (nb == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (nb == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] rd, input bit drop);
        int   w;
        int   nb;
        bus_t e;
        w = 0;
        while (lsu_ready !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("issue_ready", {31'd0, lsu_ready}, 32'd1);
        lsu_en = 1'b1; ls_is_store = st; ls_funct3 = f3; ls_addr = addr; ls_wdata = wd; ls_rd = rd;
        t_issue = cyc;
        nb = op_bytes(st, f3);
        if (nb != 0 && (addr % nb) == 0) begin
            e.we = st; e.addr = addr & ~32'd3; e.be = exp_be(st, nb, addr);
            e.wdata = exp_wd(nb, wd); e.f3 = f3; e.baddr = addr; e.rd = rd; e.drop = drop;
            bus_q.push_back(e);
        end else begin
            fault_at[cyc + 1] = 1'b1;
        end
        @(negedge clk);
        lsu_en = 1'b0;
        ls_is_store = 1'($urandom); ls_funct3 = 3'($urandom); ls_addr = $urandom;
        ls_wdata = $urandom; ls_rd = 4'($urandom);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_req"},  {31'd0, mem_req}, 32'd0);
        chk({tag, "_mem_we"},   {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_be"},   {28'd0, mem_be}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_ld_ready"}, {31'd0, ls_load_ready}, 32'd0);
        chk({tag, "_fault"},    {31'd0, ls_fault}, 32'd0);
        chk({tag, "_ld_rd"},    {28'd0, ld_rd}, 32'd0);
        chk({tag, "_ld_data"},  ld_data, 32'd0);
        chk({tag, "_lsu_ready"}, {31'd0, lsu_ready}, 32'd1);
    endtask

    // Monitor: fault pulses must land exactly where scheduled; every
    // writeback pops the oldest expected load.
    always @(negedge clk) begin
        ld_t e;
        bit  ef;
        ef = fault_at.exists(cyc) ? 1'b1 : 1'b0;
        chk("fault_pulse", {31'd0, ls_fault}, {31'd0, ef});
        if (ls_load_ready === 1'b1) begin
            if (ld_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_load_ready rd=%0d data=%h required=none", ld_rd, ld_data);
            end else begin
                e = ld_q.pop_front();
                chk("ld_rd", {28'd0, ld_rd}, {28'd0, e.rd});
                chk("ld_data", ld_data, e.data);
                chk("ready_in_pulse", {31'd0, lsu_ready}, 32'd1);
            end
            last_ld_cyc = cyc;
        end
    end

    // Memory responder: checks requests against the model, grants after a
    // stall, returns data, and injects gnt/rvalid where they must be ignored.
    always @(negedge clk) begin
        ld_t l;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        if (r_wait_ph) begin
            if (r_wait == 0) begin
                if (fix_mode) mem_rdata = fix_rdata;
                mem_rvalid = 1'b1;
                r_wait_ph  = 1'b0;
                if (!r_cur.drop && r_cur.rd != 4'd0) begin
                    l.rd = r_cur.rd;
                    l.data = load_val(r_cur.f3, r_cur.baddr, mem_rdata);
                    ld_q.push_back(l);
                end
            end else begin
                r_wait--;
                mem_gnt = ($urandom_range(0, 3) == 0);
            end
        end else if (mem_req === 1'b1) begin
            if (!r_seen) begin
                r_seen = 1'b1; r_stall = 0;
                if (bus_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_mem_req addr=%h required=none", mem_addr);
                    r_cur.we = mem_we; r_cur.addr = mem_addr; r_cur.be = mem_be;
                    r_cur.wdata = mem_wdata; r_cur.f3 = 3'd2; r_cur.baddr = mem_addr;
                    r_cur.rd = 4'd0; r_cur.drop = 1'b1;
                end else begin
                    r_cur = bus_q.pop_front();
                    chk("mem_we", {31'd0, mem_we}, {31'd0, r_cur.we});
                    chk("mem_addr", mem_addr, r_cur.addr);
                    chk("mem_be", {28'd0, mem_be}, {28'd0, r_cur.be});
                    if (r_cur.we) chk("mem_wdata", mem_wdata, r_cur.wdata);
                end
            end else begin
                chk("hold_we", {31'd0, mem_we}, {31'd0, r_cur.we});
                chk("hold_addr", mem_addr, r_cur.addr);
                chk("hold_be", {28'd0, mem_be}, {28'd0, r_cur.be});
                if (r_cur.we) chk("hold_wdata", mem_wdata, r_cur.wdata);
            end
            mem_rvalid = ($urandom_range(0, 3) == 0);
            if (fix_mode ? (r_stall >= fix_gnt) : ($urandom_range(0, 2) == 0 || r_stall >= 4)) begin
                mem_gnt = 1'b1; r_seen = 1'b0; r_last_gnt = cyc;
                if (!r_cur.we) begin
                    r_wait_ph = 1'b1;
                    r_wait = fix_mode ? fix_rv : int'($urandom_range(0, 2));
                end
            end else begin
                r_stall++;
            end
        end else begin
            mem_gnt    = ($urandom_range(0, 3) == 0);
            mem_rvalid = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset = 1'b1;
        fix_mode = 1'b1; fix_gnt = 0; fix_rv = 0; fix_rdata = 32'hDEAD_BEEF;
        // an issue presented during reset must be ignored
        lsu_en = 1'b1; ls_is_store = 1'b0; ls_funct3 = 3'd2; ls_addr = 32'h500;
        ls_wdata = 32'd0; ls_rd = 4'd9;
        repeat (3) @(negedge clk);
        check_zero("reset");
        lsu_en = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", {31'd0, lsu_ready}, 32'd1);

        // LW best-case latency
        issue(1'b0, 3'd2, 32'h100, 32'd0, 4'd5, 1'b0);
        w = t_issue;
        repeat (3) @(negedge clk);
        chk("lw_latency", last_ld_cyc, w + 3);

        // byte/halfword extension
        fix_rdata = 32'h80FF_1234;
        issue(1'b0, 3'd0, 32'h103, 32'd0, 4'd1, 1'b0);
        issue(1'b0, 3'd4, 32'h103, 32'd0, 4'd2, 1'b0);
        issue(1'b0, 3'd1, 32'h102, 32'd0, 4'd3, 1'b0);
        issue(1'b0, 3'd5, 32'h102, 32'd0, 4'd4, 1'b0);

        // SB with grant held off three cycles
        fix_gnt = 3;
        issue(1'b1, 3'd0, 32'h201, 32'h0000_00AB, 4'd0, 1'b0);
        w = 0;
        while (lsu_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("store_ready_after_gnt", cyc, r_last_gnt + 1);
        issue(1'b1, 3'd1, 32'h20E, 32'h1234_5678, 4'd0, 1'b0);
        fix_gnt = 0;

        // illegal / misaligned
        issue(1'b0, 3'd3, 32'h102, 32'd0, 4'd6, 1'b0);
        issue(1'b0, 3'd2, 32'h102, 32'd0, 4'd6, 1'b0);
        issue(1'b1, 3'd1, 32'h101, 32'd0, 4'd0, 1'b0);
        repeat (3) begin
            chk("fault_no_req", {31'd0, mem_req}, 32'd0);
            chk("fault_ready", {31'd0, lsu_ready}, 32'd1);
            @(negedge clk);
        end

        // load to x0 then back-to-back loads issued in the pulse cycle
        issue(1'b0, 3'd2, 32'h300, 32'd0, 4'd0, 1'b0);
        issue(1'b0, 3'd2, 32'h304, 32'd0, 4'd6, 1'b0);
        issue(1'b0, 3'd2, 32'h308, 32'd0, 4'd7, 1'b0);
        chk("b2b_accept_in_pulse", t_issue, last_ld_cyc);
        chk("b2b_req_next", {31'd0, mem_req}, 32'd1);

        // randomized traffic
        fix_mode = 1'b0;
        for (int i = 0; i < 250; i++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a;
            int          nb;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            st = 1'($urandom_range(0, 1));
            f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            a  = $urandom;
            nb = op_bytes(st, f3);
            if (nb != 0 && $urandom_range(0, 3) != 0) a = a & ~(32'(nb) - 32'd1);
            issue(st, f3, a, $urandom, 4'($urandom), 1'b0);
        end
        repeat (12) @(negedge clk);

        // reset while waiting for read data; rvalid lands after release
        fix_mode = 1'b1; fix_gnt = 0; fix_rv = 3; fix_rdata = 32'h1111_2222;
        issue(1'b0, 3'd2, 32'h400, 32'd0, 4'd7, 1'b1);
        @(negedge clk);
        chk("in_wait_r", {31'd0, lsu_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_zero("after_late_rvalid");

        repeat (4) @(negedge clk);
        chk("bus_q_drained", bus_q.size(), 32'd0);
        chk("ld_q_drained", ld_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
